uart_tx_word_feeder: RTL and testbench
======================================

# uart_tx_word_feeder

Buffered word source that sits directly upstream of the 32-bit UART transmitter (`UART_CODE`). It accepts 32-bit words from system logic through a valid/ready write port and stores them in an internal FIFO. It issues each word to the transmitter as a one-cycle `tx_data_valid` pulse with `tx_byte` held stable. It waits for the transmitter's `tx_done` before issuing the next word, with an optional inter-word idle gap and a watchdog on a missing `tx_done`.

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥2.
- `ADDR_W`, 3: log2(DEPTH).
- `GAP_CYCLES`, 0: idle clocks inserted after `tx_done` before the next word is issued; 0 means no gap.
- `TIMEOUT_CYCLES`, 4096: maximum clocks to wait for `tx_done` after issue; 0 disables the watchdog.
- `iclk`  in  1  system clock; all logic is on the rising edge.
- `irst`  in  1  reset; synchronous, active-high.
- `wr_valid`  in  1  write request.
- `wr_data`  in  32  word to enqueue.
- `wr_ready`  out  1  equals `!full`; a write is accepted on an edge where `wr_valid && wr_ready`.
- `tx_data_valid`  out  1  one-cycle issue pulse to the transmitter.
- `tx_byte`  out  32  word being transmitted.
- `tx_done`  in  1  transmitter completion pulse.
- `tx_active`  in  1  transmitter busy; status only, not used for the handshake.
- `fifo_count`  out  ADDR_W+1  number of stored words, 0..DEPTH.
- `busy`  out  1  FSM is not in IDLE.
- `overflow`  out  1  sticky flag: a write was attempted while full.
- `timeout`  out  1  sticky flag: the watchdog expired.

## Operation
- FIFO: circular memory with `wr_ptr`/`rd_ptr` of ADDR_W bits that wrap modulo DEPTH, plus a separate count.
  - full = (count == DEPTH); empty = (count == 0).
  - Write and pop on the same edge: count is unchanged and both pointers advance.
  - A write while full is dropped and sets `overflow`. Memory and count are untouched.
- FSM states: IDLE, WAIT_DONE, GAP.
- IDLE:
  - If not empty: `tx_byte <= mem[rd_ptr]`, pop, `tx_data_valid <= 1`, watchdog counter loads 0, go to WAIT_DONE.
  - Otherwise stay in IDLE.
- WAIT_DONE:
  - `tx_data_valid <= 0`; `tx_byte` is held.
  - If `tx_done`: go to GAP with the gap counter loaded to GAP_CYCLES-1. If GAP_CYCLES == 0, go straight to IDLE.
  - Else, if TIMEOUT_CYCLES ≠ 0 and the watchdog reaches TIMEOUT_CYCLES-1: set `timeout` and go to IDLE. The word is lost, not retried.
  - Otherwise increment the watchdog.
- GAP: decrement the counter each clock; go to IDLE on the edge where the counter is 0.
- `tx_done` seen outside WAIT_DONE is ignored.
- Reset mid-operation:
  - Takes effect on the next edge and flushes the FIFO.
  - Any word in flight is abandoned; the transmitter is not signalled.
  - Memory contents need not be cleared.
- Reset values: `tx_data_valid`=0, `tx_byte`=0, `fifo_count`=0, `wr_ready`=1, `busy`=0, `overflow`=0, `timeout`=0, state=IDLE, pointers=0.

## Timing
- Write accepted at edge E0 with the FIFO empty and FSM in IDLE:
  - `fifo_count`=1 after E0.
  - `tx_data_valid` is high from E1 to E2, exactly one cycle; `tx_byte` is valid from E1.
  - `fifo_count` returns to 0 after E1.
- `tx_byte` stays stable from the issue edge until the next issue or reset.
- `tx_done` sampled high at edge Ed:
  - GAP_CYCLES=0: state is IDLE after Ed, and the next `tx_data_valid` rises at Ed+1.
  - GAP_CYCLES=G: the next `tx_data_valid` rises at Ed+G+1.
- `wr_ready` is combinational from count. A pop on an edge frees a slot that is visible on the next cycle.
- `tx_data_valid` is never high on two consecutive cycles. At most one word is outstanding.
- `busy` is registered state decode and is high from the issue edge until the return to IDLE.

## Test plan
- Single word:
  - Stimulus: reset, then write 0x0F3CC3F0.
  - Required: one `tx_data_valid` pulse 1 cycle after acceptance, `tx_byte`=0x0F3CC3F0, and after the bench's `tx_done` the FSM returns to IDLE with `fifo_count`=0.
- Back-to-back:
  - Stimulus: write 0x0F3CC3F0 then 0xFFFFFFFF on consecutive cycles, with GAP_CYCLES=0 and a `UART_CODE` model (86 clocks per bit).
  - Required: second pulse occurs exactly 1 cycle after the first `tx_done`, with `tx_byte`=0xFFFFFFFF.
- Full/overflow:
  - Stimulus: hold `tx_done` low and write DEPTH+2 words 0x1..0xA.
  - Required: `wr_ready`=0 once `fifo_count`=DEPTH, `overflow`=1, and the words are emitted in order 0x1.. with the dropped words absent.
- Simultaneous push and pop:
  - Stimulus: a write on the same edge IDLE pops with count=3.
  - Required: `fifo_count` stays 3, and pointer wrap past DEPTH-1 preserves order.
- Gap and watchdog:
  - Gap: with GAP_CYCLES=5, measure 6 clocks from `tx_done` to the next pulse.
  - Watchdog: with TIMEOUT_CYCLES=16 and `tx_done` withheld, `timeout` sets after 16 clocks, then the next queued word is issued.
- Reset mid-transfer:
  - Stimulus: assert `irst` during WAIT_DONE with 3 words queued.
  - Required: after the edge, all outputs are at reset values, and a later `tx_done` causes no pulse.

Source files
------------

// File: rtl/uart_tx_word_feeder.sv
// rtl/uart_tx_word_feeder.sv - buffered 32-bit word source feeding the UART transmitter one word at a time
//
// Ports:
//   iclk, irst            clock, synchronous active-high reset
//   wr_valid/wr_data      write port; accepted when wr_valid && wr_ready
//   wr_ready              FIFO not full
//   tx_data_valid/tx_byte one-cycle issue pulse and held word to the transmitter
//   tx_done               transmitter completion pulse
//   tx_active             transmitter busy (status only)
//   fifo_count            stored words, 0..DEPTH
//   busy                  FSM not in IDLE
//   overflow, timeout     sticky error flags

module uart_tx_word_feeder #(
    parameter int DEPTH          = 8,
    parameter int ADDR_W         = 3,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              wr_valid,
    input  logic [31:0]       wr_data,
    output logic              wr_ready,
    output logic              tx_data_valid,
    output logic [31:0]       tx_byte,
    input  logic              tx_done,
    input  logic              tx_active,
    output logic [ADDR_W:0]   fifo_count,
    output logic              busy,
    output logic              overflow,
    output logic              timeout
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [WD_W-1:0]   WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DONE = 2'd1,
        S_GAP       = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [GAP_W-1:0]  gap_cnt;
    logic [WD_W-1:0]   wd_cnt;

    logic full;
    logic empty;
    logic push;
    logic issue;
    logic done_seen;
    logic wd_expire;

    // Transmitter busy is informational only; the handshake relies on tx_done.
    logic unused_tx_active;
    assign unused_tx_active = tx_active;

    assign full       = (count == FULL_COUNT);
    assign empty      = (count == '0);
    assign push       = wr_valid && !full;
    assign wr_ready   = !full;
    assign fifo_count = count;
    assign busy       = (state != S_IDLE);

    // State register
    always_ff @(posedge iclk) begin
        if (irst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (issue) begin
                    state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (done_seen) begin
                    state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end else if (wd_expire) begin
                    state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Per-state control decode; tx_done outside WAIT_DONE never reaches done_seen
    always_comb begin
        issue     = 1'b0;
        done_seen = 1'b0;
        wd_expire = 1'b0;
        case (state)
            S_IDLE: begin
                issue = !empty;
            end
            S_WAIT_DONE: begin
                done_seen = tx_done;
                wd_expire = !tx_done && (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST);
            end
            default: begin
            end
        endcase
    end

    // FIFO storage; not reset, pointers and count define validity
    always_ff @(posedge iclk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO bookkeeping, issue register, counters and sticky flags
    always_ff @(posedge iclk) begin
        if (irst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            tx_data_valid <= 1'b0;
            tx_byte       <= '0;
            gap_cnt       <= '0;
            wd_cnt        <= '0;
            overflow      <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (wr_valid && full) begin
                overflow <= 1'b1;
            end
            if (wd_expire) begin
                timeout <= 1'b1;
            end

            // Only IDLE can raise issue, so the pulse is always a single cycle
            tx_data_valid <= issue;

            if (issue) begin
                tx_byte <= mem[rd_ptr];
                wd_cnt  <= '0;
            end else if (state == S_WAIT_DONE) begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            if (done_seen) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_word_feeder.sv
// tb/tb_uart_tx_word_feeder.sv - directed self-checking bench for uart_tx_word_feeder

module tb_uart_tx_word_feeder;

    localparam int FRAME_CLKS = 86 * 34;

    logic iclk = 1'b0;
    logic irst;
    always #5 iclk = ~iclk;

    // Instance A: no gap, default watchdog
    logic        a_wv;
    logic [31:0] a_wd;
    logic        a_wrdy;
    logic        a_txv;
    logic [31:0] a_byte;
    logic        a_done;
    logic        a_active;
    logic [3:0]  a_cnt;
    logic        a_busy;
    logic        a_ovf;
    logic        a_to;

    // Instance B: 5-cycle gap, 16-cycle watchdog
    logic        b_wv;
    logic [31:0] b_wd;
    logic        b_wrdy;
    logic        b_txv;
    logic [31:0] b_byte;
    logic        b_done;
    logic [3:0]  b_cnt;
    logic        b_busy;
    logic        b_ovf;
    logic        b_to;

    logic        man_done;
    logic        model_en;
    logic        a_mdone;
    int          mcnt;

    int total = 0;
    int bad   = 0;

    assign a_done   = model_en ? a_mdone : man_done;
    assign a_active = (mcnt != 0);

    uart_tx_word_feeder #(.DEPTH(8), .ADDR_W(3), .GAP_CYCLES(0), .TIMEOUT_CYCLES(4096)) dut_a (
        .iclk(iclk), .irst(irst), .wr_valid(a_wv), .wr_data(a_wd), .wr_ready(a_wrdy),
        .tx_data_valid(a_txv), .tx_byte(a_byte), .tx_done(a_done), .tx_active(a_active),
        .fifo_count(a_cnt), .busy(a_busy), .overflow(a_ovf), .timeout(a_to)
    );

    uart_tx_word_feeder #(.DEPTH(8), .ADDR_W(3), .GAP_CYCLES(5), .TIMEOUT_CYCLES(16)) dut_b (
        .iclk(iclk), .irst(irst), .wr_valid(b_wv), .wr_data(b_wd), .wr_ready(b_wrdy),
        .tx_data_valid(b_txv), .tx_byte(b_byte), .tx_done(b_done), .tx_active(1'b0),
        .fifo_count(b_cnt), .busy(b_busy), .overflow(b_ovf), .timeout(b_to)
    );

    // Transmitter model: tx_done one frame after the issue pulse
    always @(posedge iclk) begin
        a_mdone <= 1'b0;
        if (a_txv && model_en) begin
            mcnt <= FRAME_CLKS;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) a_mdone <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic pulse_done();
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
    endtask

    // tx_data_valid must never be high on two consecutive cycles
    logic mon_on = 1'b0;
    logic a_txv_q, b_txv_q;
    always @(posedge iclk) begin
        a_txv_q <= a_txv;
        b_txv_q <= b_txv;
    end
    always @(negedge iclk) begin
        if (mon_on) begin
            check("a_txv_consecutive", {31'd0, a_txv_q & a_txv}, 32'd0);
            check("b_txv_consecutive", {31'd0, b_txv_q & b_txv}, 32'd0);
        end
    end

    initial begin
        int found;
        int n_meas;

        irst = 1'b1; a_wv = 1'b0; a_wd = '0; b_wv = 1'b0; b_wd = '0;
        b_done = 1'b0; man_done = 1'b0; model_en = 1'b0; mcnt = 0; a_mdone = 1'b0;
        tick(); tick();
        irst = 1'b0;
        mon_on = 1'b1;

        // Reset state
        check("rst_txv", a_txv, 0);
        check("rst_byte", a_byte, 0);
        check("rst_count", a_cnt, 0);
        check("rst_wr_ready", a_wrdy, 1);
        check("rst_busy", a_busy, 0);
        check("rst_overflow", a_ovf, 0);
        check("rst_timeout", a_to, 0);

        // Single word
        a_wv = 1'b1; a_wd = 32'h0F3CC3F0;
        tick();
        a_wv = 1'b0;
        check("single_count_e0", a_cnt, 1);
        check("single_txv_e0", a_txv, 0);
        tick();
        check("single_txv_e1", a_txv, 1);
        check("single_byte", a_byte, 32'h0F3CC3F0);
        check("single_count_e1", a_cnt, 0);
        check("single_busy", a_busy, 1);
        tick();
        check("single_txv_e2", a_txv, 0);
        check("single_byte_hold", a_byte, 32'h0F3CC3F0);
        pulse_done();
        check("single_idle", a_busy, 0);
        check("single_count_end", a_cnt, 0);
        tick();
        check("single_no_repeat", a_txv, 0);

        // Back-to-back with transmitter model
        model_en = 1'b1;
        a_wv = 1'b1; a_wd = 32'h0F3CC3F0;
        tick();
        a_wd = 32'hFFFFFFFF;
        tick();
        a_wv = 1'b0;
        check("b2b_first_pulse", a_txv, 1);
        check("b2b_first_byte", a_byte, 32'h0F3CC3F0);
        found = 0;
        for (int n = 0; n < 5000; n++) begin
            tick();
            if (a_done) begin found = 1; break; end
        end
        check("b2b_done1_seen", found, 1);
        tick();
        check("b2b_idle_at_ed", a_busy, 0);
        check("b2b_no_pulse_at_ed", a_txv, 0);
        tick();
        check("b2b_second_pulse", a_txv, 1);
        check("b2b_second_byte", a_byte, 32'hFFFFFFFF);
        found = 0;
        for (int n = 0; n < 5000; n++) begin
            tick();
            if (a_done) begin found = 1; break; end
        end
        check("b2b_done2_seen", found, 1);
        tick();
        model_en = 1'b0;
        check("b2b_idle_end", a_busy, 0);

        // Full / overflow: 0x1 issues, 0x2..0x9 fill, 0xA is dropped
        for (int i = 1; i <= 10; i++) begin
            a_wv = 1'b1; a_wd = i;
            tick();
        end
        a_wv = 1'b0;
        check("full_count", a_cnt, 8);
        check("full_wr_ready", a_wrdy, 0);
        check("full_overflow", a_ovf, 1);
        check("full_first_byte", a_byte, 32'h1);
        for (int k = 2; k <= 9; k++) begin
            pulse_done();
            tick();
            check("full_drain_txv", a_txv, 1);
            check("full_drain_byte", a_byte, k);
        end
        pulse_done();
        tick();
        check("full_no_dropped_word", a_txv, 0);
        check("full_drained_count", a_cnt, 0);
        check("full_overflow_sticky", a_ovf, 1);

        // Simultaneous push and pop at count 3, pointers wrapping
        a_wv = 1'b1; a_wd = 32'h11; tick();
        a_wd = 32'h12; tick();
        a_wd = 32'h13; tick();
        a_wd = 32'h14; tick();
        a_wv = 1'b0;
        check("pp_count_setup", a_cnt, 3);
        check("pp_byte_setup", a_byte, 32'h11);
        for (int j = 0; j < 8; j++) begin
            pulse_done();
            a_wv = 1'b1; a_wd = 32'h15 + j;
            tick();
            a_wv = 1'b0;
            check("pp_txv", a_txv, 1);
            check("pp_byte", a_byte, 32'h12 + j);
            check("pp_count", a_cnt, 3);
        end
        for (int k = 0; k < 3; k++) begin
            pulse_done();
            tick();
            check("pp_drain_byte", a_byte, 32'h1A + k);
            check("pp_drain_count", a_cnt, 2 - k);
        end
        pulse_done();
        tick();
        check("pp_end_txv", a_txv, 0);
        check("pp_end_count", a_cnt, 0);

        // Reset mid-transfer with 3 words queued
        for (int i = 0; i < 4; i++) begin
            a_wv = 1'b1; a_wd = 32'h21 + i;
            tick();
        end
        a_wv = 1'b0;
        check("mrst_count_before", a_cnt, 3);
        check("mrst_busy_before", a_busy, 1);
        irst = 1'b1;
        tick();
        irst = 1'b0;
        check("mrst_txv", a_txv, 0);
        check("mrst_byte", a_byte, 0);
        check("mrst_count", a_cnt, 0);
        check("mrst_wr_ready", a_wrdy, 1);
        check("mrst_busy", a_busy, 0);
        check("mrst_overflow", a_ovf, 0);
        check("mrst_timeout", a_to, 0);
        pulse_done();
        tick();
        check("mrst_late_done_txv", a_txv, 0);
        check("mrst_late_done_busy", a_busy, 0);
        check("mrst_late_done_count", a_cnt, 0);

        // Gap of 5 cycles on instance B
        b_wv = 1'b1; b_wd = 32'h31; tick();
        b_wd = 32'h32; tick();
        b_wv = 1'b0;
        check("gap_first_pulse", b_txv, 1);
        check("gap_first_byte", b_byte, 32'h31);
        tick(); tick();
        b_done = 1'b1;
        tick();
        b_done = 1'b0;
        check("gap_busy_in_gap", b_busy, 1);
        n_meas = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (b_txv) begin n_meas = n; break; end
        end
        check("gap_clocks", n_meas, 6);
        check("gap_second_byte", b_byte, 32'h32);

        // Watchdog: withhold tx_done for 0x32, 0x33 queued behind it
        b_wv = 1'b1; b_wd = 32'h33; tick();
        b_wv = 1'b0;
        check("wd_not_yet", b_to, 0);
        n_meas = 0;
        for (int n = 2; n <= 40; n++) begin
            tick();
            if (b_to) begin n_meas = n; break; end
        end
        check("wd_clocks", n_meas, 16);
        check("wd_txv_at_expire", b_txv, 0);
        check("wd_idle_at_expire", b_busy, 0);
        tick();
        check("wd_next_pulse", b_txv, 1);
        check("wd_next_byte", b_byte, 32'h33);
        check("wd_sticky", b_to, 1);
        check("wd_count", b_cnt, 0);

        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
